// File: rtl/resp_pkg.sv
// Shared types, frame lengths and ASCII constants for the response formatter.
// RESP_HELP_TEXT_EN selects whether code 3 decodes to HELP or falls back to FAIL.
package resp_pkg;

    typedef enum logic [2:0] {
        RESP_OK     = 3'd0,
        RESP_FAIL   = 3'd1,
        RESP_STATUS = 3'd2,
        RESP_HELP   = 3'd3
    } resp_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } fmt_state_e;

    localparam int IDX_W = 6;

    localparam logic [IDX_W-1:0] LEN_OK     = 6'd4;
    localparam logic [IDX_W-1:0] LEN_FAIL   = 6'd6;
    localparam logic [IDX_W-1:0] LEN_STATUS = 6'd17;
    localparam logic [IDX_W-1:0] LEN_HELP   = 6'd36;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;
    localparam logic [7:0] ASCII_SP   = 8'h20;

    // Unknown codes (and HELP when its text is not built in) collapse to FAIL.
    function automatic resp_code_e decode_code(input logic [2:0] raw);
        resp_code_e code;
        case (raw)
            3'd0:    code = RESP_OK;
            3'd2:    code = RESP_STATUS;
`ifdef RESP_HELP_TEXT_EN
            3'd3:    code = RESP_HELP;
`endif
            default: code = RESP_FAIL;
        endcase
        return code;
    endfunction

    function automatic logic [IDX_W-1:0] frame_len(input resp_code_e code);
        logic [IDX_W-1:0] len;
        case (code)
            RESP_OK:     len = LEN_OK;
            RESP_STATUS: len = LEN_STATUS;
            RESP_HELP:   len = LEN_HELP;
            default:     len = LEN_FAIL;
        endcase
        return len;
    endfunction

    // Clamp to 99, then split into {tens, units} by repeated subtraction.
    function automatic logic [7:0] duty_digits(input logic [6:0] duty);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = (duty > 7'd99) ? 7'd99 : duty;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rem)};
    endfunction

endpackage

// File: rtl/resp_char_rom.sv
// Combinational character lookup: (code, byte index, digits) -> ASCII byte.
// The HELP text table exists only when RESP_HELP_TEXT_EN is defined.
module resp_char_rom
    import resp_pkg::*;
(
    input  resp_code_e       code,
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       tens,
    input  logic [3:0]       units,
    input  logic [1:0]       pow2,
    input  logic [1:0]       pow5,
    output logic [7:0]       char_out
);

`ifdef RESP_HELP_TEXT_EN
    localparam int HELP_LEN      = int'(LEN_HELP);
    localparam int HELP_BODY_LEN = HELP_LEN - 2;
    localparam logic [8*HELP_BODY_LEN-1:0] HELP_TEXT = "CMDS: HELP STATUS DCnn POW2n POW5n";

    logic [7:0] help_table [0:HELP_LEN-1];

    for (genvar gi = 0; gi < HELP_BODY_LEN; gi++) begin : g_help_text
        assign help_table[gi] = HELP_TEXT[8*(HELP_BODY_LEN-1-gi) +: 8];
    end
    assign help_table[HELP_LEN-2] = ASCII_CR;
    assign help_table[HELP_LEN-1] = ASCII_LF;
`endif

    always_comb begin
        char_out = 8'h00;
        case (code)
            RESP_OK: begin
                case (idx)
                    6'd0:    char_out = "O";
                    6'd1:    char_out = "K";
                    6'd2:    char_out = ASCII_CR;
                    6'd3:    char_out = ASCII_LF;
                    default: char_out = 8'h00;
                endcase
            end
            RESP_STATUS: begin
                case (idx)
                    6'd0:    char_out = "D";
                    6'd1:    char_out = "C";
                    6'd2:    char_out = ASCII_EQ;
                    6'd3:    char_out = ASCII_ZERO + {4'd0, tens};
                    6'd4:    char_out = ASCII_ZERO + {4'd0, units};
                    6'd5:    char_out = ASCII_SP;
                    6'd6:    char_out = "P";
                    6'd7:    char_out = "2";
                    6'd8:    char_out = ASCII_EQ;
                    6'd9:    char_out = ASCII_ZERO + {6'd0, pow2};
                    6'd10:   char_out = ASCII_SP;
                    6'd11:   char_out = "P";
                    6'd12:   char_out = "5";
                    6'd13:   char_out = ASCII_EQ;
                    6'd14:   char_out = ASCII_ZERO + {6'd0, pow5};
                    6'd15:   char_out = ASCII_CR;
                    6'd16:   char_out = ASCII_LF;
                    default: char_out = 8'h00;
                endcase
            end
`ifdef RESP_HELP_TEXT_EN
            RESP_HELP: begin
                if (idx < LEN_HELP) begin
                    char_out = help_table[idx];
                end
            end
`endif
            default: begin
                case (idx)
                    6'd0:    char_out = "F";
                    6'd1:    char_out = "A";
                    6'd2:    char_out = "I";
                    6'd3:    char_out = "L";
                    6'd4:    char_out = ASCII_CR;
                    6'd5:    char_out = ASCII_LF;
                    default: char_out = 8'h00;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/response_formatter.sv
// Turns a response request into an ASCII frame streamed byte-by-byte to a UART TX.
// Define RESP_HELP_TEXT_EN to build in the 36-byte HELP text for code 3.
module response_formatter
    import resp_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_code,
    input  logic [6:0] duty_cycle,
    input  logic [1:0] pow2,
    input  logic [1:0] pow5,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       frame_done
);

    localparam logic [3:0] GAP_M1 = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    fmt_state_e       state_reg;
    resp_code_e       code_reg;
    logic [IDX_W-1:0] byte_idx_reg;
    logic [3:0]       gap_cnt_reg;
    logic [3:0]       tens_reg;
    logic [3:0]       units_reg;
    logic [1:0]       pow2_reg;
    logic [1:0]       pow5_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_valid_reg;
    logic             frame_done_reg;
    logic             req_ready_reg;

    resp_code_e       req_code_dec;
    logic [7:0]       req_digits;
    logic             accept;
    logic             xfer;
    logic             last_byte;

    resp_code_e       rom_code;
    logic [IDX_W-1:0] rom_idx;
    logic [3:0]       rom_tens;
    logic [3:0]       rom_units;
    logic [1:0]       rom_pow2;
    logic [1:0]       rom_pow5;
    logic [7:0]       rom_char;

    assign req_code_dec = decode_code(req_code);
    assign req_digits   = duty_digits(duty_cycle);
    assign accept       = req_valid && req_ready_reg;
    assign xfer         = tx_valid_reg && tx_ready;
    assign last_byte    = (byte_idx_reg == frame_len(code_reg) - 6'd1);

    // The ROM always looks up the byte that will be loaded at the next edge:
    // byte 0 of the incoming request in IDLE, the following byte in SEND,
    // and the already-advanced index while waiting out a gap.
    always_comb begin
        rom_code  = code_reg;
        rom_idx   = byte_idx_reg;
        rom_tens  = tens_reg;
        rom_units = units_reg;
        rom_pow2  = pow2_reg;
        rom_pow5  = pow5_reg;
        case (state_reg)
            ST_IDLE: begin
                rom_code  = req_code_dec;
                rom_idx   = '0;
                rom_tens  = req_digits[7:4];
                rom_units = req_digits[3:0];
                rom_pow2  = pow2;
                rom_pow5  = pow5;
            end
            ST_SEND: rom_idx = byte_idx_reg + 6'd1;
            default: ;
        endcase
    end

    resp_char_rom u_char_rom (
        .code     (rom_code),
        .idx      (rom_idx),
        .tens     (rom_tens),
        .units    (rom_units),
        .pow2     (rom_pow2),
        .pow5     (rom_pow5),
        .char_out (rom_char)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            code_reg       <= RESP_OK;
            byte_idx_reg   <= '0;
            gap_cnt_reg    <= '0;
            tens_reg       <= '0;
            units_reg      <= '0;
            pow2_reg       <= '0;
            pow5_reg       <= '0;
            tx_data_reg    <= 8'h00;
            tx_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            req_ready_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        code_reg      <= req_code_dec;
                        tens_reg      <= req_digits[7:4];
                        units_reg     <= req_digits[3:0];
                        pow2_reg      <= pow2;
                        pow5_reg      <= pow5;
                        byte_idx_reg  <= '0;
                        tx_data_reg   <= rom_char;
                        tx_valid_reg  <= 1'b1;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (last_byte) begin
                            state_reg      <= ST_IDLE;
                            byte_idx_reg   <= '0;
                            tx_valid_reg   <= 1'b0;
                            frame_done_reg <= 1'b1;
                            req_ready_reg  <= 1'b1;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 6'd1;
                            if (GAP_CYCLES == 0) begin
                                tx_data_reg <= rom_char;
                            end else begin
                                tx_valid_reg <= 1'b0;
                                gap_cnt_reg  <= GAP_M1;
                                state_reg    <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == 4'd0) begin
                        tx_data_reg  <= rom_char;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_SEND;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign tx_data    = tx_data_reg;
    assign tx_valid   = tx_valid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_response_formatter.sv
// Scoreboard bench for response_formatter: a string-built reference model queues expected
// bytes, a negedge monitor compares them; a second instance checks GAP_CYCLES=3 timing.
`timescale 1ns/1ps
module tb_response_formatter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_ready;
    logic [2:0] req_code;
    logic [6:0] duty_cycle;
    logic [1:0] pow2, pow5;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, frame_done;

    logic       req_valid_g, req_ready_g;
    logic [2:0] req_code_g;
    logic [6:0] duty_cycle_g;
    logic [1:0] pow2_g, pow5_g;
    logic [7:0] tx_data_g;
    logic       tx_valid_g, tx_ready_g, frame_done_g;

    response_formatter #(.GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_code(req_code), .duty_cycle(duty_cycle), .pow2(pow2), .pow5(pow5),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_done(frame_done)
    );

    response_formatter #(.GAP_CYCLES(3)) dut_gap (
        .clk(clk), .rst(rst), .req_valid(req_valid_g), .req_ready(req_ready_g),
        .req_code(req_code_g), .duty_cycle(duty_cycle_g), .pow2(pow2_g), .pow5(pow5_g),
        .tx_data(tx_data_g), .tx_valid(tx_valid_g), .tx_ready(tx_ready_g), .frame_done(frame_done_g)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    bit         last_q[$];

    bit         tied = 1'b1;
    int         cyc = 0;
    int         last_cyc = 0;
    int         bytes_in_frame = 0;
    int         frames_done = 0;
    bit         pend_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endfunction

    // Reference model: the frame text is composed directly from the protocol rules.
    function automatic int push_frame(input logic [2:0] code, input int duty, input int p2, input int p5);
        string body;
        int d;
        case (code)
            3'd0: body = "OK";
            3'd2: begin
                d = (duty > 99) ? 99 : duty;
                body = $sformatf("DC=%0d%0d P2=%0d P5=%0d", d / 10, d % 10, p2, p5);
            end
`ifdef RESP_HELP_TEXT_EN
            3'd3: body = "CMDS: HELP STATUS DCnn POW2n POW5n";
`endif
            default: body = "FAIL";
        endcase
        for (int i = 0; i < body.len(); i++) begin
            exp_q.push_back(body[i]);
            last_q.push_back(1'b0);
        end
        exp_q.push_back(8'h0D); last_q.push_back(1'b0);
        exp_q.push_back(8'h0A); last_q.push_back(1'b1);
        return body.len() + 2;
    endfunction

    // Monitor: tx_ready is chosen first, so tx_valid && tx_ready here means the
    // byte transfers at the coming rising edge.
    always @(negedge clk) begin
        logic [7:0] e;
        bit         l;
        cyc++;
        tx_ready = tied ? 1'b1 : 1'($urandom_range(0, 1));
        if (rst) begin
            check("rst_tx_valid", tx_valid, 0);
            check("rst_tx_data", tx_data, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_req_ready", req_ready, 0);
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (pend_done) begin
                check("frame_done_pulse", frame_done, 1);
                check("ready_with_done", req_ready, 1);
                pend_done = 1'b0;
            end else if (frame_done) begin
                n_checks++;
                $display("FAIL spurious_frame_done: got 1 required 0");
            end
            if (prev_stall) begin
                check("stall_hold_valid", tx_valid, 1);
                check("stall_hold_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got %02h required no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    l = last_q.pop_front();
                    check("tx_byte", tx_data, e);
                    if (tied && bytes_in_frame > 0) check("back_to_back", cyc - last_cyc, 1);
                    last_cyc = cyc;
                    bytes_in_frame++;
                    if (l) begin
                        pend_done = 1'b1;
                        frames_done++;
                        bytes_in_frame = 0;
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL req_ready_timeout: got 0 required 1");
        end
    endtask

    task automatic send_req(input logic [2:0] code, input logic [6:0] duty, input logic [1:0] p2,
                            input logic [1:0] p5, input bit random_ready, input bit mid_req);
        int t, target, len;
        wait_ready();
        tied       = !random_ready;
        req_valid  = 1'b1;
        req_code   = code;
        duty_cycle = duty;
        pow2       = p2;
        pow5       = p5;
        target     = frames_done + 1;
        @(posedge clk);
        len = push_frame(code, int'(duty), int'(p2), int'(p5));
        $display("req code=%0d duty=%0d p2=%0d p5=%0d ready=%s bytes=%0d",
                 code, duty, p2, p5, random_ready ? "random" : "tied", len);
        #1;
        check("latency1_valid", tx_valid, 1);
        check("ready_drop", req_ready, 0);
        req_code   = 3'($urandom);
        duty_cycle = 7'($urandom);
        pow2       = 2'($urandom);
        pow5       = 2'($urandom);
        if (mid_req) begin
            req_code = 3'd0;
            repeat (2) begin
                @(negedge clk);
                check("mid_frame_not_ready", req_ready, 0);
            end
        end
        req_valid = 1'b0;
        t = 0;
        while (!(frames_done == target && !pend_done) && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            $display("FAIL frame_timeout: got %0d frames required %0d", frames_done, target);
        end
    endtask

    task automatic reset_mid_status();
        int t = 0;
        wait_ready();
        tied       = 1'b1;
        req_valid  = 1'b1;
        req_code   = 3'd2;
        duty_cycle = 7'd42;
        pow2       = 2'd1;
        pow5       = 2'd2;
        @(posedge clk);
        void'(push_frame(3'd2, 42, 1, 2));
        $display("req code=2 duty=42 p2=1 p5=2 ready=tied bytes=17 (reset after byte 5)");
        #1 req_valid = 1'b0;
        while (bytes_in_frame < 5 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("bytes_before_reset", bytes_in_frame, 5);
        #1 rst = 1'b1;
        #1;
        check("abort_tx_valid", tx_valid, 0);
        exp_q.delete();
        last_q.delete();
        bytes_in_frame = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", req_ready, 1);
        check("no_valid_after_release", tx_valid, 0);
    endtask

    task automatic gap_test();
        logic [7:0] exp_b [4];
        int nb = 0;
        int zero_run = 0;
        bit started = 1'b0;
        bit done_seen = 1'b0;
        exp_b[0] = 8'h4F; exp_b[1] = 8'h4B; exp_b[2] = 8'h0D; exp_b[3] = 8'h0A;
        @(negedge clk);
        check("gap_ready_idle", req_ready_g, 1);
        req_valid_g = 1'b1;
        req_code_g  = 3'd0;
        $display("req gap3 code=0 ready=tied bytes=4");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 6) req_valid_g = 1'b0;
            if (i >= 1 && i <= 5) check("gap_mid_not_ready", req_ready_g, 0);
            if (tx_valid_g) begin
                if (nb > 0) check("gap_len", zero_run, 3);
                if (nb < 4) check("gap_byte", tx_data_g, exp_b[nb]);
                nb++;
                zero_run = 0;
                started  = 1'b1;
            end else if (started && !done_seen) begin
                zero_run++;
            end
            if (frame_done_g) begin
                done_seen = 1'b1;
                check("gap_done_after_4", nb, 4);
            end
        end
        check("gap_total_bytes", nb, 4);
        check("gap_done_seen", done_seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_code = '0; duty_cycle = '0; pow2 = '0; pow5 = '0;
        tx_ready = 1'b1;
        req_valid_g = 1'b0; req_code_g = '0; duty_cycle_g = '0; pow2_g = '0; pow5_g = '0;
        tx_ready_g = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_first_cycle", req_ready, 1);

        send_req(3'd0, 7'd0,   2'd0, 2'd0, 1'b0, 1'b1);
        send_req(3'd2, 7'd7,   2'd3, 2'd0, 1'b0, 1'b0);
        send_req(3'd2, 7'd120, 2'd1, 2'd2, 1'b0, 1'b0);
        send_req(3'd6, 7'd0,   2'd0, 2'd0, 1'b1, 1'b0);
        send_req(3'd3, 7'd0,   2'd0, 2'd0, 1'b0, 1'b0);
        send_req(3'd3, 7'd55,  2'd2, 2'd1, 1'b1, 1'b1);
        send_req(3'd2, 7'd99,  2'd3, 2'd3, 1'b1, 1'b0);
        send_req(3'd2, 7'd100, 2'd0, 2'd1, 1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            send_req(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        reset_mid_status();
        send_req(3'd0, 7'd0, 2'd0, 2'd0, 1'b0, 1'b0);

        gap_test();

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/response_formatter.md
RESPONSE_FORMATTER -- requirements
Module: response_formatter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between consecutive bytes of one frame (0..15).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  response request present.
REQ-005 SHALL have port req_ready  output  1  formatter can accept a request.
REQ-006 SHALL have port req_code  input  3  0=OK, 1=FAIL, 2=STATUS, 3=HELP, 4..7=unknown.
REQ-007 SHALL have port duty_cycle  input  7  duty value for STATUS (0..127).
REQ-008 SHALL have ports pow2 and pow5  input  2 each  power settings for STATUS.
REQ-009 SHALL have port tx_data  output  8  ASCII byte to UART TX.
REQ-010 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-011 SHALL have port tx_ready  input  1  UART TX accepts the byte this cycle.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after the last byte of a frame.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, GAP; reset state IDLE.
REQ-014 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready.
REQ-015 SHALL capture req_code, duty_cycle, pow2 and pow5 on acceptance; later input changes do not affect the frame.
REQ-016 SHALL enter SEND the cycle after acceptance, with tx_valid=1 and the first byte on tx_data (latency 1).
REQ-017 SHALL hold tx_data stable and tx_valid high until tx_ready=1; a byte transfers on tx_valid&&tx_ready.
REQ-018 SHALL, after a non-final transfer, advance the byte index; with GAP_CYCLES=0 it SHALL present the next byte the following cycle, otherwise it SHALL go to GAP for exactly GAP_CYCLES cycles with tx_valid=0.
REQ-019 SHALL, on transfer of the final byte, go to IDLE, pulse frame_done for the next cycle, and assert req_ready that same cycle.
REQ-020 SHALL send OK as "OK\r\n" (4 bytes).
REQ-021 SHALL send FAIL, and any code 4..7, as "FAIL\r\n" (6 bytes).
REQ-022 SHALL send STATUS as "DC=tu P2=a P5=b\r\n" (17 bytes): tu is two decimal digits with a leading zero; a and b are single digits 0..3.
REQ-023 SHALL clamp a captured duty_cycle above 99 to 99 for display.
REQ-024 SHALL compute the digits by division-free subtract-10 iteration or a constant lookup; results SHALL be exact for 0..99.
REQ-025 SHALL send HELP as "CMDS: HELP STATUS DCnn POW2n POW5n\r\n" (36 bytes) when the HELP feature is compiled in.
REQ-026 SHALL ignore req_valid outside IDLE; there SHALL be no queuing.
REQ-027 SHALL allow tx_ready to be high while tx_valid=0; such cycles SHALL have no effect.

Reset
REQ-028 SHALL, while rst is high, force state=IDLE, byte index=0, gap counter=0, tx_valid=0, tx_data=8'h00, frame_done=0, req_ready=0.
REQ-029 SHALL assert req_ready the first cycle after rst deasserts.
REQ-030 SHALL, on reset mid-frame, abort the frame; no remaining bytes are sent after release.

Configuration
REQ-031 SHALL, with macro RESP_HELP_TEXT_EN defined, include the 36-byte HELP text.
REQ-032 SHALL, without RESP_HELP_TEXT_EN, treat code 3 as unknown and send "FAIL\r\n"; no HELP storage is synthesized.

Structure
REQ-033 SHALL place the response code enum, the frame lengths (4/6/17/36) and the ASCII constants (CR, LF, '0', '=', space) in package resp_pkg.
REQ-034 SHALL use one combinational sub-module resp_char_rom mapping (code, index, digits) to a byte.

Verification
REQ-035 SHALL cover: code 0, tx_ready tied 1 -> bytes 4F 4B 0D 0A on 4 consecutive cycles, then frame_done, then req_ready=1.
REQ-036 SHALL cover: code 2, duty 7, pow2=3, pow5=0 -> "DC=07 P2=3 P5=0\r\n" (17 bytes); duty 120 -> "DC=99 ...".
REQ-037 SHALL cover: code 6, tx_ready toggled randomly -> "FAIL\r\n", with tx_data stable whenever tx_valid=1 and tx_ready=0.
REQ-038 SHALL cover: code 3 in both builds -> 36-byte HELP text with RESP_HELP_TEXT_EN defined, "FAIL\r\n" without it.
REQ-039 SHALL cover: GAP_CYCLES=3, code 0 -> exactly 3 tx_valid=0 cycles between the 4 bytes; a second req_valid mid-frame is ignored.
REQ-040 SHALL cover: rst pulsed after byte 5 of STATUS -> tx_valid=0 immediately, req_ready=1 after release, and a new OK frame sent correctly.
